// File: rtl/apb4_slave_pkg.sv
// apb4_slave_pkg: shared types, constants and helpers for the APB4 slave interface.
package apb4_slave_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int WAIT_CNT_W = 4;

   function automatic int idx_width(input int num_regs);
      return (num_regs <= 1) ? 1 : $clog2(num_regs);
   endfunction

endpackage

// File: rtl/apb4_addr_decode.sv
// apb4_addr_decode: maps a byte address onto a register index with range, alignment and read-only checks.
module apb4_addr_decode
   import apb4_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h80000000,
   parameter int                    NUM_REGS     = 28,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
   localparam int                   IDX_W        = idx_width(NUM_REGS)
) (
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   output logic [IDX_W-1:0]      idx,
   output logic                  in_range,
   output logic                  aligned,
   output logic                  ro_violation
);

   localparam int                  BYTES   = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LIMIT   = (ADDR_WIDTH + 1)'(NUM_REGS * BYTES);
   localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);

   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] raw_idx;

   // addresses below the base wrap to huge offsets and fail the range test
   assign off          = paddr - BASE_ADDRESS;
   assign raw_idx      = off / BYTES_A;
   assign in_range     = {1'b0, off} < LIMIT;
   assign aligned      = (off % BYTES_A) == '0;
   assign idx          = in_range ? raw_idx[IDX_W-1:0] : '0;
   assign ro_violation = pwrite & RO_MASK[idx];

endmodule

// File: rtl/apb4_slave_interface.sv
// apb4_slave_interface: APB4 slave front end with wait states, byte strobes and error response,
// producing one-cycle per-register read/write enables for a peripheral register file.
module apb4_slave_interface
   import apb4_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h80000000,
   parameter int                    NUM_REGS     = 28,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    WAIT_STATES  = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
   localparam int                   BYTES        = DATA_WIDTH / 8
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic [ADDR_WIDTH-1:0]                PADDR,
   input  logic                                 PSEL,
   input  logic                                 PENABLE,
   input  logic                                 PWRITE,
   input  logic [DATA_WIDTH-1:0]                PWDATA,
   input  logic [BYTES-1:0]                     PSTRB,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  read_data,
   output logic [NUM_REGS-1:0]                  w_enable,
   output logic [NUM_REGS-1:0]                  r_enable,
   output logic [DATA_WIDTH-1:0]                w_data,
   output logic [BYTES-1:0]                     w_strb,
   output logic [DATA_WIDTH-1:0]                PRDATA,
   output logic                                 PREADY,
   output logic                                 PSLVERR
);

   localparam int IDX_W = idx_width(NUM_REGS);

   state_t                  state;
   logic [WAIT_CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]        idx_q;
   logic                    err_q;
   logic                    wr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [BYTES-1:0]        strb_q;
   logic [IDX_W-1:0]        dec_idx;
   logic                    in_range;
   logic                    aligned;
   logic                    ro_violation;
   logic                    done;
   logic                    wr_ok;
   logic                    rd_ok;

   apb4_addr_decode #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .BASE_ADDRESS (BASE_ADDRESS),
      .NUM_REGS     (NUM_REGS),
      .DATA_WIDTH   (DATA_WIDTH),
      .RO_MASK      (RO_MASK)
   ) u_decode (
      .paddr        (PADDR),
      .pwrite       (PWRITE),
      .idx          (dec_idx),
      .in_range     (in_range),
      .aligned      (aligned),
      .ro_violation (ro_violation)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (state == IDLE) begin
         if (PSEL && !PENABLE) begin
            state   <= ACCESS;
            cnt     <= WAIT_CNT_W'(WAIT_STATES);
            idx_q   <= dec_idx;
            err_q   <= ~in_range | ~aligned | ro_violation;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
         end
      end else if (!PSEL || done) begin
         state <= IDLE;
      end else if (PENABLE && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // a dropped PSEL aborts the access, so completion also requires PSEL
   assign done  = (state == ACCESS) & PSEL & PENABLE & (cnt == '0);
   assign wr_ok = done & ~err_q & wr_q & (|strb_q);
   assign rd_ok = done & ~err_q & ~wr_q;

   always_comb begin
      PREADY   = done;
      PSLVERR  = done & err_q;
      w_enable = wr_ok ? NUM_REGS'(1) << idx_q : '0;
      r_enable = rd_ok ? NUM_REGS'(1) << idx_q : '0;
      w_data   = wr_ok ? wdata_q : '0;
      w_strb   = wr_ok ? strb_q : '0;
      PRDATA   = rd_ok ? read_data[idx_q] : '0;
   end

endmodule

// File: tb/tb_apb4_slave_interface.sv
// tb_apb4_slave_interface: randomized APB4 transfers on two slave configurations, checked
// against an address-arithmetic reference model.
module tb_apb4_slave_interface;

   localparam logic [31:0] BASE = 32'h80000000;

   logic               clk = 1'b0;
   logic               n_rst = 1'b0;
   logic [31:0]        PADDR = '0;
   logic               PSEL = 1'b0;
   logic               PENABLE = 1'b0;
   logic               PWRITE = 1'b0;
   logic [31:0]        PWDATA = '0;
   logic [3:0]         PSTRB = '0;
   logic [27:0][31:0]  rd = '0;
   logic               dut = 1'b0;

   logic [27:0] w_en0, w_en3, r_en0, r_en3, w_enable, r_enable;
   logic [31:0] w_data0, w_data3, prdata0, prdata3, w_data, PRDATA;
   logic [3:0]  w_strb0, w_strb3, w_strb;
   logic        pready0, pready3, pslverr0, pslverr3, PREADY, PSLVERR;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   apb4_slave_interface #(.WAIT_STATES(0)) u0 (
      .clk(clk), .n_rst(n_rst), .PADDR(PADDR), .PSEL(PSEL & ~dut), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .read_data(rd),
      .w_enable(w_en0), .r_enable(r_en0), .w_data(w_data0), .w_strb(w_strb0),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb4_slave_interface #(.WAIT_STATES(3), .RO_MASK(28'h4)) u3 (
      .clk(clk), .n_rst(n_rst), .PADDR(PADDR), .PSEL(PSEL & dut), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .read_data(rd),
      .w_enable(w_en3), .r_enable(r_en3), .w_data(w_data3), .w_strb(w_strb3),
      .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
   );

   assign w_enable = dut ? w_en3 : w_en0;
   assign r_enable = dut ? r_en3 : r_en0;
   assign w_data   = dut ? w_data3 : w_data0;
   assign w_strb   = dut ? w_strb3 : w_strb0;
   assign PRDATA   = dut ? prdata3 : prdata0;
   assign PREADY   = dut ? pready3 : pready0;
   assign PSLVERR  = dut ? pslverr3 : pslverr0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".pready"}, PREADY, 0);
      check({tag, ".pslverr"}, PSLVERR, 0);
      check({tag, ".w_enable"}, w_enable, 0);
      check({tag, ".r_enable"}, r_enable, 0);
      check({tag, ".prdata"}, PRDATA, 0);
      check({tag, ".w_data"}, w_data, 0);
      check({tag, ".w_strb"}, w_strb, 0);
   endtask

   task automatic randomize_regs();
      for (int i = 0; i < 28; i++) rd[i] = $urandom;
   endtask

   // reference model: offset arithmetic decides error/target, then one full transfer is checked
   task automatic xfer(input logic d, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st);
      int          ws;
      logic [31:0] ro;
      logic [31:0] off;
      logic        err;
      int          reg_n;
      logic [27:0] e_w;
      logic [27:0] e_r;
      ws    = d ? 3 : 0;
      ro    = d ? 32'h4 : 32'h0;
      off   = a - BASE;
      reg_n = int'(off / 4);
      err   = (off >= 32'd112) || (off % 4 != 0);
      if (!err && wr && ro[reg_n]) err = 1'b1;
      e_w   = (!err && wr && st != 0) ? 28'(1) << reg_n : 28'h0;
      e_r   = (!err && !wr) ? 28'(1) << reg_n : 28'h0;
      dut = d;
      randomize_regs();
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd; PSTRB = st;
      @(posedge clk); #1;
      PENABLE = 1'b1; PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom); PWRITE = ~wr;
      for (int k = 0; k <= ws; k++) begin
         @(negedge clk);
         check("pready", PREADY, k == ws);
         check("pslverr", PSLVERR, (k == ws) && err);
         check("w_enable", w_enable, (k == ws) ? e_w : 28'h0);
         check("r_enable", r_enable, (k == ws) ? e_r : 28'h0);
         check("w_data", w_data, (k == ws && e_w != 0) ? wd : 32'h0);
         check("w_strb", w_strb, (k == ws && e_w != 0) ? st : 4'h0);
         check("prdata", PRDATA, (k == ws && e_r != 0) ? rd[reg_n] : 32'h0);
         @(posedge clk); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge clk);
      check_quiet("idle_after");
   endtask

   initial begin
      #2;
      check_quiet("reset");
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;
      for (int i = 0; i < 28; i++) xfer(1'b0, BASE + 32'(4 * i), 1'b1, $urandom, 4'hF);
      for (int i = 0; i < 28; i++) xfer(1'b0, BASE + 32'(4 * i), 1'b0, 32'h0, 4'h0);
      xfer(1'b1, 32'h80000008, 1'b0, 32'h0, 4'h0);
      xfer(1'b0, 32'h80000070, 1'b0, 32'h0, 4'h0);
      xfer(1'b0, 32'h80000006, 1'b1, $urandom, 4'hF);
      xfer(1'b0, 32'h7FFFFFFC, 1'b1, $urandom, 4'hF);
      xfer(1'b1, 32'h80000008, 1'b1, $urandom, 4'hF);
      xfer(1'b1, 32'h80000004, 1'b1, $urandom, 4'h0);
      xfer(1'b1, 32'h8000000C, 1'b1, $urandom, 4'h5);
      xfer(1'b1, 32'h8000006C, 1'b1, $urandom, 4'hA);
      // abort: PSEL dropped in the second access cycle
      dut = 1'b1;
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h80000010; PWRITE = 1'b1; PWDATA = $urandom; PSTRB = 4'hF;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      PSEL = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_quiet("abort");
      end
      PENABLE = 1'b0;
      xfer(1'b1, 32'h80000010, 1'b1, $urandom, 4'hF);
      // reset in the first access cycle of a wait-state transfer
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h80000014; PWRITE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      #2 n_rst = 1'b0;
      #1 check_quiet("rst_ws3");
      @(posedge clk); #3 n_rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_quiet("post_rst_ws3");
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      // reset asserted during a completion cycle must clear live outputs at once
      dut = 1'b0;
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h80000018; PWRITE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(negedge clk);
      check("rst_pre.r_enable", r_enable, 28'h40);
      #1 n_rst = 1'b0;
      #1 check_quiet("rst_done");
      @(posedge clk); #3 n_rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_quiet("post_rst_ws0");
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) == 0) ? $urandom : BASE + 32'($urandom_range(0, 127));
         xfer(1'($urandom), a, 1'($urandom), $urandom, 4'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
